// File: rtl/rr_select_arbiter_pkg.sv
// Shared types and constants for the round-robin select arbiter.
// The FSM state type and channel geometry live here for all users.
package rr_select_arbiter_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(
        input logic [SEL_W-1:0] s
    );
        logic [NUM_CH-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_select_arbiter_if.sv
// Request/grant bundle between the requesters and the select arbiter.
// slave is the arbiter side, master is the requester side.
interface rr_select_arbiter_if;
    import rr_select_arbiter_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              done;
    logic [SEL_W-1:0]  select;
    logic              grant_valid;
    logic [NUM_CH-1:0] grant_onehot;
    logic              timeout;

    modport slave (
        input  req,
        input  done,
        output select,
        output grant_valid,
        output grant_onehot,
        output timeout
    );

    modport master (
        output req,
        output done,
        input  select,
        input  grant_valid,
        input  grant_onehot,
        input  timeout
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational first-set search of the request vector starting at ptr.
// Returns the winning channel and whether any channel is requesting.
module rr_priority_pick
    import rr_select_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [SEL_W-1:0]  o_winner,
    output logic              o_any
);

    always_comb begin
        logic [SEL_W-1:0] v_idx;
        o_winner = '0;
        o_any    = 1'b0;
        v_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v_idx = i_ptr + SEL_W'(i);
            if (!o_any && i_req[v_idx]) begin
                o_winner = v_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select with a bounded hold time.
// Every output comes straight from a register; the grant is re-arbitrated after an idle bubble.
module rr_select_arbiter
    import rr_select_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_select_arbiter_if.slave  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  w_ptr_nxt;
    logic [SEL_W-1:0]  r_select;
    logic [SEL_W-1:0]  w_select_nxt;
    logic [7:0]        r_hold_cnt;
    logic [7:0]        w_hold_cnt_nxt;
    logic [NUM_CH-1:0] r_onehot;
    logic [NUM_CH-1:0] w_onehot_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    logic [SEL_W-1:0]  w_winner;
    logic              w_any;
    logic              w_early_rel;
    logic              w_hold_rel;

    rr_priority_pick u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // done or a dropped request wins over the hold limit, so no timeout then
    assign w_early_rel = bus.done || !bus.req[r_select];
    assign w_hold_rel  = (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_select   <= '0;
            r_hold_cnt <= '0;
            r_onehot   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_select   <= w_select_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_onehot   <= w_onehot_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_select_nxt   = r_select;
        w_hold_cnt_nxt = r_hold_cnt;
        w_onehot_nxt   = r_onehot;
        w_timeout_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_onehot_nxt = '0;
                if (w_any) begin
                    w_state_nxt    = ST_GRANT;
                    w_select_nxt   = w_winner;
                    w_hold_cnt_nxt = '0;
                    w_onehot_nxt   = sel_onehot(w_winner);
                end
            end
            ST_GRANT: begin
                if (w_early_rel || w_hold_rel) begin
                    w_state_nxt   = ST_IDLE;
                    w_ptr_nxt     = r_select + SEL_W'(1);
                    w_onehot_nxt  = '0;
                    w_timeout_nxt = !w_early_rel;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.select       = r_select;
    assign bus.grant_valid  = (r_state == ST_GRANT);
    assign bus.grant_onehot = r_onehot;
    assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed and randomized checks of rr_select_arbiter against a grant-level model.
// The model tracks owner, cycles held and rotation priority as plain integers.
module tb_rr_select_arbiter;
    import rr_select_arbiter_pkg::*;

    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst_n;

    rr_select_arbiter_if bus();

    rr_select_arbiter #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // model: owner -1 means no grant; held counts grant cycles so far
    int m_owner;
    int m_held;
    int m_prio;
    int m_sel;
    bit m_to;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_prio  = 0;
        m_sel   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic d);
        bit found;
        m_to  = 1'b0;
        found = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_prio + k) % 4;
                if (!found && r[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_sel   = c;
                    m_held  = 1;
                end
            end
        end else if (d || !r[m_owner]) begin
            m_prio  = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (m_held == MH) begin
            m_to    = 1'b1;
            m_prio  = (m_owner + 1) % 4;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] oh;
        oh = (m_owner >= 0) ? 8'(1 << m_owner) : 8'd0;
        chk({tag, ".gv"}, 8'(bus.grant_valid), 8'(m_owner >= 0));
        chk({tag, ".sel"}, 8'(bus.select), 8'(m_sel));
        chk({tag, ".oh"}, 8'(bus.grant_onehot), oh);
        chk({tag, ".to"}, 8'(bus.timeout), 8'(m_to));
    endtask

    // called at a negedge: drive, clock, update model, check at next negedge
    task automatic step(input logic [3:0] r, input logic d,
                        input string tag);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_edge(r, d);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;
    endtask

    int exp_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        int g;
        logic [3:0] rr;
        logic dd;

        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();
        #2;
        check_all("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // single request, then done; next winner search starts at 3
        step(4'b0100, 1'b0, "r030a");
        chk("r030sel", 8'(bus.select), 8'd2);
        chk("r030oh", 8'(bus.grant_onehot), 8'h04);
        step(4'b0100, 1'b1, "r030done");
        chk("r030idle", 8'(bus.grant_valid), 8'd0);
        step(4'b1111, 1'b0, "r030ptr");
        chk("r030ptr3", 8'(bus.select), 8'd3);
        step(4'b0000, 1'b0, "r030drop");

        // full rotation with done pulsed on each grant
        do_reset();
        g = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'(m_owner >= 0), "r031");
            if (m_owner >= 0 && g < 5) begin
                chk("r031seq", 8'(bus.select), 8'(exp_seq[g]));
                g++;
            end
        end
        chk("r031cnt", 8'(g), 8'd5);

        // hold limit with a single continuous requester
        do_reset();
        for (int i = 0; i < MH; i++) step(4'b0001, 1'b0, "r032h");
        chk("r032gv8", 8'(bus.grant_valid), 8'd1);
        step(4'b0001, 1'b0, "r032rel");
        chk("r032to", 8'(bus.timeout), 8'd1);
        chk("r032bub", 8'(bus.grant_valid), 8'd0);
        step(4'b0001, 1'b0, "r032re");
        chk("r032regr", 8'(bus.grant_valid), 8'd1);

        // done on the hold-limit cycle releases without timeout
        for (int i = 0; i < MH - 1; i++) step(4'b0001, 1'b0, "r033h");
        step(4'b0001, 1'b1, "r033rel");
        chk("r033to", 8'(bus.timeout), 8'd0);
        chk("r033gv", 8'(bus.grant_valid), 8'd0);

        // requester drops mid-grant with others pending
        do_reset();
        step(4'b1111, 1'b0, "r034a");
        step(4'b1111, 1'b0, "r034b");
        step(4'b1110, 1'b0, "r034rel");
        chk("r034to", 8'(bus.timeout), 8'd0);
        step(4'b1110, 1'b0, "r034next");
        chk("r034sel", 8'(bus.select), 8'd1);

        // asynchronous reset mid-grant
        step(4'b1110, 1'b0, "r035pre");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("r035gv", 8'(bus.grant_valid), 8'd0);
        chk("r035sel", 8'(bus.select), 8'd0);
        chk("r035oh", 8'(bus.grant_onehot), 8'd0);
        chk("r035to", 8'(bus.timeout), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1010, 1'b0, "r035g");
        chk("r035first", 8'(bus.select), 8'd1);

        // randomized traffic with sticky requests to reach hold limits
        rr = 4'($urandom_range(0, 15));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rr = 4'($urandom_range(0, 15));
            dd = ($urandom_range(0, 9) == 0);
            step(rr, dd, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
